mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester controller for a single shared memory port. The instruction-fetch path (requester 0) and the load/store path (requester 1) take turns on one memory port. The block drives the select line of the 1-bit 2-way mux bank that routes address and data to the port. It also enables the port for a fixed access latency and returns a one-cycle completion pulse to whichever requester was granted.

## Interface
- `ACC_LAT`, default 2: memory access latency in cycles (legal range 1..15)
- `CNT_W`, default 4: width of the latency counter (2^CNT_W must be > ACC_LAT)
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `req0`  in  1  fetch request; level, held until `ack0`
- `req1`  in  1  load/store request; level, held until `ack1`
- `sel`  out  1  mux select; 0 routes requester 0, 1 routes requester 1
- `mem_en`  out  1  memory port enable; high for the whole access
- `ack0`  out  1  one-cycle pulse when requester 0's access completes
- `ack1`  out  1  one-cycle pulse when requester 1's access completes

## Operation
- **States:**
  - IDLE: port free.
  - ACCESS: port owned by the requester named by `sel`.
- **IDLE:**
  - No `req` high: stay in IDLE.
  - One `req` high: grant it.
  - Both high: grant the requester that is not `last`.
  - On grant, load `sel` with the winner, set `mem_en`=1, load `cnt`=ACC_LAT-1 and move to ACCESS.
  - Set `last`=winner at the same edge.
- **ACCESS:**
  - `cnt`>0: `cnt` decrements each cycle.
  - `cnt`==0: the winner's `ack` is high for that cycle, and the next edge returns to IDLE with `mem_en`=0.
  - `sel` is held through IDLE; it changes only on a new grant.
- **Requester rule:** a requester deasserts `req` on the same edge that samples its `ack`=1, unless it has a new request.
  - A `req` still high in the IDLE cycle after `ack` is a new request.
- **Dropped request:** `req` dropping during ACCESS is ignored; the access completes and `ack` still pulses.
- **Exclusivity:** `ack0` and `ack1` are never high together. No `ack` occurs without a preceding grant.
- **Registered outputs:** all outputs come from flops; no combinational path from `req` to any output.

## Timing
- **Reset values:** on `reset` high at an edge:
  - state=IDLE, `sel`=0, `mem_en`=0, `ack0`=`ack1`=0, `cnt`=0.
  - `last`=1, so requester 0 wins the first tie.
- **Reset mid-access:** the access is aborted and no `ack` is issued.
- **Latency:** `req` sampled high at the end of IDLE cycle t gives:
  - ACCESS in cycles t+1 .. t+ACC_LAT;
  - `ack` in cycle t+ACC_LAT;
  - IDLE in cycle t+ACC_LAT+1.
- **Throughput:** at most one access per ACC_LAT+1 cycles. There is one mandatory idle turnaround cycle between accesses.
- **ACC_LAT=1:** ACCESS lasts one cycle, with `ack` in that same cycle.
- **Round-robin fairness:** under continuous contention, grants alternate 0,1,0,1… Neither requester waits more than one access.

## Configuration
- `ARB_FIXED_PRIORITY_EN` defined:
  - Requester 1 (load/store) always wins simultaneous requests.
  - `last` is not updated and has no effect.
  - Requester 0 can starve under continuous `req1`.
- `ARB_FIXED_PRIORITY_EN` undefined (default): round-robin as described in Operation.

## Test plan
- **Reset then single request:** `reset` for 2 cycles, then `req0`=1 from cycle 3 with ACC_LAT=2 -> `mem_en`=1 and `sel`=0 in cycles 4-5, `ack0` in cycle 5 only, `mem_en`=0 in cycle 6.
- **Contention:** `req0`=`req1`=1 held continuously for 12 cycles, ACC_LAT=2 -> grants 0,1,0,1; `ack0` pulses at cycles 3 and 9, `ack1` at cycles 6 and 12; never both high.
- **Fixed priority:** same stimulus with `ARB_FIXED_PRIORITY_EN` defined -> only `ack1` pulses and `sel` stays 1.
- **Reset mid-access:** `req1` granted, `reset` asserted in the first ACCESS cycle -> next cycle `mem_en`=0, `sel`=0, no `ack1`; after reset release, a tie is granted to requester 0.
- **Early drop and ACC_LAT=1:** with ACC_LAT=3, `req1` dropped one cycle after grant -> `ack1` still pulses 3 cycles after grant. Rebuild with ACC_LAT=1 and assert `req0` -> `ack0` 1 cycle after the request is sampled, one access every 2 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/completion bundle between two requesters and the shared memory port arbiter.
interface mem_port_arbiter_if;
   logic req0;
   logic req1;
   logic sel;
   logic mem_en;
   logic ack0;
   logic ack1;

   modport master (output req0, output req1, input sel, input mem_en, input ack0, input ack1);
   modport slave  (input req0, input req1, output sel, output mem_en, output ack0, output ack1);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one memory port with fixed access latency; round-robin on ties.
// Define ARB_FIXED_PRIORITY_EN to make requester 1 (load/store) always win ties instead.
module mem_port_arbiter #(
   parameter int ACC_LAT = 2,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ACC_LAT - 1);
   localparam bit               SINGLE = (ACC_LAT == 1);

   state_t           r_state;
   logic             r_sel;
   logic             r_mem_en;
   logic             r_ack0;
   logic             r_ack1;
   logic [CNT_W-1:0] r_cnt;
   logic             w_any;
   logic             w_winner;
`ifndef ARB_FIXED_PRIORITY_EN
   logic             r_last;
`endif

   always_comb begin
      w_any = bus.req0 | bus.req1;
`ifdef ARB_FIXED_PRIORITY_EN
      w_winner = bus.req1;
`else
      w_winner = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_sel    <= 1'b0;
         r_mem_en <= 1'b0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_cnt    <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
         r_last   <= 1'b1;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state  <= S_ACCESS;
                  r_sel    <= w_winner;
                  r_mem_en <= 1'b1;
                  r_cnt    <= LAT_M1;
                  // A one-cycle access completes in its first ACCESS cycle.
                  r_ack0   <= SINGLE && !w_winner;
                  r_ack1   <= SINGLE && w_winner;
`ifndef ARB_FIXED_PRIORITY_EN
                  r_last   <= w_winner;
`endif
               end
            end
            S_ACCESS: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
                  // Ack is registered so it lands in the cycle where the count reaches zero.
                  if (r_cnt == CNT_W'(1)) begin
                     r_ack0 <= ~r_sel;
                     r_ack1 <= r_sel;
                  end
               end else begin
                  r_state  <= S_IDLE;
                  r_mem_en <= 1'b0;
                  r_ack0   <= 1'b0;
                  r_ack1   <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.sel    = r_sel;
   assign bus.mem_en = r_mem_en;
   assign bus.ack0   = r_ack0;
   assign bus.ack1   = r_ack1;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Checks three arbiter builds (ACC_LAT 2, 3, 1) against a grant-time/latency model every cycle.
module tb_mem_port_arbiter;
   localparam int NDUT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if b0();
   mem_port_arbiter_if b1();
   mem_port_arbiter_if b2();

   mem_port_arbiter #(.ACC_LAT(2), .CNT_W(4)) u_dut0 (.clk(clk), .reset(rst), .bus(b0));
   mem_port_arbiter #(.ACC_LAT(3), .CNT_W(4)) u_dut1 (.clk(clk), .reset(rst), .bus(b1));
   mem_port_arbiter #(.ACC_LAT(1), .CNT_W(4)) u_dut2 (.clk(clk), .reset(rst), .bus(b2));

   logic       r0 [NDUT];
   logic       r1 [NDUT];
   logic [3:0] out_v [NDUT];   // {sel, mem_en, ack0, ack1}

   assign b0.req0 = r0[0];
   assign b0.req1 = r1[0];
   assign b1.req0 = r0[1];
   assign b1.req1 = r1[1];
   assign b2.req0 = r0[2];
   assign b2.req1 = r1[2];
   assign out_v[0] = {b0.sel, b0.mem_en, b0.ack0, b0.ack1};
   assign out_v[1] = {b1.sel, b1.mem_en, b1.ack0, b1.ack1};
   assign out_v[2] = {b2.sel, b2.mem_en, b2.ack0, b2.ack1};

   function automatic int lat_of(int k);
      case (k)
         0: return 2;
         1: return 3;
         default: return 1;
      endcase
   endfunction

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model: a grant at the end of cycle g owns the port for cycles g+1..g+L, acks in g+L.
   bit         m_busy  [NDUT];
   int         m_grant [NDUT];
   bit         m_owner [NDUT];
   bit         m_last  [NDUT];
   bit         m_sel   [NDUT];
   logic [3:0] exp_v   [NDUT];
   bit         exp_valid = 1'b0;

   int  ack_n [NDUT];
   int  ack_c [NDUT][16];
   bit  ack_w [NDUT][16];
   int  pend0 [NDUT];
   int  pend1 [NDUT];

   initial begin
      forever begin
         @(posedge clk);
         for (int k = 0; k < NDUT; k++) begin
            int  lat;
            bit  win;
            lat = lat_of(k);
            if (rst) begin
               m_busy[k] = 1'b0;
               m_sel[k]  = 1'b0;
               m_last[k] = 1'b1;
            end else if (m_busy[k]) begin
               if (cyc >= m_grant[k] + lat) m_busy[k] = 1'b0;
            end else if (r0[k] || r1[k]) begin
`ifdef ARB_FIXED_PRIORITY_EN
               win = r1[k];
`else
               win = (r0[k] && r1[k]) ? !m_last[k] : r1[k];
               m_last[k] = win;
`endif
               m_busy[k]  = 1'b1;
               m_grant[k] = cyc;
               m_owner[k] = win;
               m_sel[k]   = win;
            end
            exp_v[k] = {m_sel[k], m_busy[k],
                        m_busy[k] && (cyc + 1 == m_grant[k] + lat) && !m_owner[k],
                        m_busy[k] && (cyc + 1 == m_grant[k] + lat) && m_owner[k]};
         end
         cyc = cyc + 1;
         exp_valid = 1'b1;
      end
   end

   initial begin
      string nm [4];
      nm[0] = "ack1"; nm[1] = "ack0"; nm[2] = "mem_en"; nm[3] = "sel";
      forever begin
         @(negedge clk);
         if (exp_valid) begin
            for (int k = 0; k < NDUT; k++) begin
               for (int b = 0; b < 4; b++) begin
                  checks++;
                  if (out_v[k][b] !== exp_v[k][b]) begin
                     errors++;
                     $display("FAIL dut%0d %s cycle %0d got %b expected %b",
                              k, nm[b], cyc, out_v[k][b], exp_v[k][b]);
                  end
               end
               if ((out_v[k][1] === 1'b1 || out_v[k][0] === 1'b1) && ack_n[k] < 16) begin
                  ack_c[k][ack_n[k]] = cyc;
                  ack_w[k][ack_n[k]] = out_v[k][0];
                  ack_n[k]++;
                  $display("dut%0d cycle %0d ack%0d", k, cyc, out_v[k][0] ? 1 : 0);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, expv);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < NDUT; k++) begin
         r0[k] = (pend0[k] > 0);
         r1[k] = (pend1[k] > 0);
      end
   endtask

   // Requesters drop req on the edge that samples their ack unless more work is pending.
   task automatic step();
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         if (out_v[k][1] === 1'b1 && pend0[k] > 0) pend0[k]--;
         if (out_v[k][0] === 1'b1 && pend1[k] > 0) pend1[k]--;
      end
      drive();
   endtask

   task automatic clear_log();
      for (int k = 0; k < NDUT; k++) ack_n[k] = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int waited;
      for (int k = 0; k < NDUT; k++) begin
         pend0[k] = 0; pend1[k] = 0; ack_n[k] = 0;
      end
      rst = 1'b1;
      drive();
      repeat (2) step();
      rst = 1'b0;

      // Single request after reset.
      clear_log();
      for (int k = 0; k < NDUT; k++) pend0[k] = 1;
      drive();
      s = cyc;
      repeat (6) step();
      chk("single_n0", ack_n[0], 1);
      chk("single_c0", ack_c[0][0], s + 2);
      chk("single_c1", ack_c[1][0], s + 3);
      chk("single_c2", ack_c[2][0], s + 1);
      chk("single_w0", ack_w[0][0], 0);

      // Contention from a fresh reset.
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_log();
      for (int k = 0; k < NDUT; k++) begin pend0[k] = 2; pend1[k] = 2; end
      drive();
      s = cyc;
      repeat (18) step();
      chk("cont_n0", ack_n[0], 4);
      chk("cont_c0_0", ack_c[0][0], s + 2);
      chk("cont_c0_1", ack_c[0][1], s + 5);
      chk("cont_c0_2", ack_c[0][2], s + 8);
      chk("cont_c0_3", ack_c[0][3], s + 11);
      chk("cont_c1_3", ack_c[1][3], s + 15);
      chk("cont_c2_3", ack_c[2][3], s + 7);
`ifdef ARB_FIXED_PRIORITY_EN
      chk("cont_w0_0", ack_w[0][0], 1);
      chk("cont_w0_1", ack_w[0][1], 1);
      chk("cont_w0_2", ack_w[0][2], 0);
      chk("cont_w1_1", ack_w[1][1], 1);
`else
      chk("cont_w0_0", ack_w[0][0], 0);
      chk("cont_w0_1", ack_w[0][1], 1);
      chk("cont_w0_2", ack_w[0][2], 0);
      chk("cont_w1_1", ack_w[1][1], 1);
`endif

      // Reset during the first ACCESS cycle of a requester-1 grant.
      clear_log();
      for (int k = 0; k < NDUT; k++) pend1[k] = 1;
      drive();
      waited = 0;
      step();
      while (out_v[0][2] !== 1'b1 && waited < 10) begin
         step();
         waited++;
      end
      chk("rst_grant_seen", (out_v[0][2] === 1'b1) ? 1 : 0, 1);
      rst = 1'b1;
      for (int k = 0; k < NDUT; k++) begin pend0[k] = 0; pend1[k] = 0; end
      drive();
      step();
      chk("rst_outputs0", int'(out_v[0]), 0);
      chk("rst_noack0", ack_n[0], 0);
      chk("rst_noack1", ack_n[1], 0);
      rst = 1'b0;
      clear_log();
      for (int k = 0; k < NDUT; k++) begin pend0[k] = 1; pend1[k] = 1; end
      drive();
      s = cyc;
      repeat (10) step();
      chk("rst_tie_c0", ack_c[0][0], s + 2);
`ifdef ARB_FIXED_PRIORITY_EN
      chk("rst_tie_w0", ack_w[0][0], 1);
`else
      chk("rst_tie_w0", ack_w[0][0], 0);
`endif

      // Requester 1 drops its request one cycle after grant.
      clear_log();
      for (int k = 0; k < NDUT; k++) pend1[k] = 1;
      drive();
      s = cyc;
      step();
      for (int k = 0; k < NDUT; k++) pend1[k] = 0;
      drive();
      repeat (6) step();
      chk("drop_n1", ack_n[1], 1);
      chk("drop_c1", ack_c[1][0], s + 3);
      chk("drop_w1", ack_w[1][0], 1);
      chk("drop_c0", ack_c[0][0], s + 2);

      // Back-to-back requester-0 accesses: one per ACC_LAT+1 cycles.
      clear_log();
      for (int k = 0; k < NDUT; k++) pend0[k] = 3;
      drive();
      s = cyc;
      repeat (12) step();
      chk("tput_n2", ack_n[2], 3);
      chk("tput_c2_0", ack_c[2][0], s + 1);
      chk("tput_c2_1", ack_c[2][1], s + 3);
      chk("tput_c2_2", ack_c[2][2], s + 5);
      chk("tput_c0_2", ack_c[0][2], s + 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
